// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared widths and FSM state encoding for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

endpackage : sdram_arb_pkg
`default_nettype wire

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter_if
// Description : Requester-side and controller-side bundle of the SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3
);
    logic [NUM_PORTS-1:0]             port_req;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0]             port_write;
    logic [NUM_PORTS-1:0][DATA_W-1:0] port_wdata;
    logic [NUM_PORTS-1:0][MASK_W-1:0] port_wmask;
    logic [NUM_PORTS-1:0]             port_ack;
    logic [DATA_W-1:0]                port_rdata;
    logic [NUM_PORTS-1:0]             port_rdvalid;
    logic [NUM_PORTS-1:0]             port_complete;

    logic                             sdram_req;
    logic [ADDR_W-1:0]                sdram_addr;
    logic                             sdram_write;
    logic [DATA_W-1:0]                sdram_wdata;
    logic [MASK_W-1:0]                sdram_wmask;
    logic                             sdram_ack;
    logic [DATA_W-1:0]                sdram_rdata;
    logic                             sdram_rdvalid;
    logic                             sdram_complete;

    // Arbiter view
    modport slave (
        input  port_req, port_addr, port_write, port_wdata, port_wmask,
        output port_ack, port_rdata, port_rdvalid, port_complete,
        output sdram_req, sdram_addr, sdram_write, sdram_wdata, sdram_wmask,
        input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
    );

    // Requesters plus controller view
    modport master (
        output port_req, port_addr, port_write, port_wdata, port_wmask,
        input  port_ack, port_rdata, port_rdvalid, port_complete,
        input  sdram_req, sdram_addr, sdram_write, sdram_wdata, sdram_wmask,
        output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
    );

endinterface : sdram_port_arbiter_if
`default_nettype wire

// File: rtl/sdram_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search over ports 1..NUM_PORTS-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_PORTS = 3,
    localparam int PTR_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:1] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [PTR_W-1:0]     winner_o,
    output logic                 found_o
);

    logic             hit_hi;
    logic             hit_lo;
    logic [PTR_W-1:0] idx_hi;
    logic [PTR_W-1:0] idx_lo;

    // Descending scan leaves the lowest index; the "hi" pass only sees ports at/after ptr.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = NUM_PORTS - 1; i >= 1; i--) begin
            if (req_i[i]) begin
                if (i >= int'(ptr_i)) begin
                    hit_hi = 1'b1;
                    idx_hi = PTR_W'(i);
                end
                hit_lo = 1'b1;
                idx_lo = PTR_W'(i);
            end
        end
        found_o  = hit_lo;
        winner_o = hit_hi ? idx_hi : idx_lo;
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : One-transaction-at-a-time SDRAM port arbiter, port 0 fixed
//               priority, others round-robin. SDRAM_ARB_STARVE_GUARD_EN adds
//               a port-0 starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    sdram_port_arbiter_if.slave   bus
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic [PTR_W-1:0]  rr_win;
    logic              rr_found;
    logic              force_rr;
    logic              any_req;
    logic              grant;
    logic              done;
    logic [PTR_W-1:0]  win;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_rr_picker (
        .req_i    (bus.port_req[NUM_PORTS-1:1]),
        .ptr_i    (rr_ptr_q),
        .winner_o (rr_win),
        .found_o  (rr_found)
    );

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_rr = (starve_q == CNT_W'(STARVE_LIMIT)) && rr_found;

    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if (win == '0) starve_d = (starve_q == '1) ? starve_q : starve_q + CNT_W'(1);
            else           starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_rr = 1'b0;
`endif

    assign any_req = |bus.port_req;
    assign grant   = (state_q == ARB_IDLE) && any_req;
    assign win     = (bus.port_req[0] && !force_rr) ? '0 : rr_win;
    assign done    = ((state_q == ARB_REQ) && bus.sdram_ack && bus.sdram_complete) ||
                     ((state_q == ARB_WAIT) && bus.sdram_complete);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= PTR_W'(1);
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: if (any_req) begin
                state_d = ARB_REQ;
                owner_d = win;
            end
            ARB_REQ:  if (bus.sdram_ack) state_d = bus.sdram_complete ? ARB_IDLE : ARB_WAIT;
            ARB_WAIT: if (bus.sdram_complete) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (done && owner_q != '0)
            rr_ptr_d = (owner_q == PTR_W'(NUM_PORTS - 1)) ? PTR_W'(1) : owner_q + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant) begin
            addr_q  <= bus.port_addr[win];
            write_q <= bus.port_write[win];
            wdata_q <= bus.port_wdata[win];
            wmask_q <= bus.port_wmask[win];
        end
    end

    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_write = write_q;
    assign bus.sdram_wdata = wdata_q;
    assign bus.sdram_wmask = wmask_q;
    assign bus.port_rdata  = bus.sdram_rdata;

    // Controller strobes seen in IDLE belong to no one and are dropped.
    always_comb begin
        bus.sdram_req     = (state_q == ARB_REQ);
        bus.port_ack      = '0;
        bus.port_rdvalid  = '0;
        bus.port_complete = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (owner_q == PTR_W'(i)) begin
                bus.port_ack[i]      = bus.sdram_ack && (state_q == ARB_REQ);
                bus.port_rdvalid[i]  = bus.sdram_rdvalid && (state_q != ARB_IDLE);
                bus.port_complete[i] = bus.sdram_complete && (state_q != ARB_IDLE);
            end
        end
    end

endmodule : sdram_port_arbiter
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Randomized self-checking bench with a grant-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int N = 3;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int LIMIT = 4;
`endif

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    int   m_rr;
    int   m_cnt;
    int   last_w;

    sdram_port_arbiter_if #(.NUM_PORTS(N)) bus ();

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    sdram_port_arbiter #(.NUM_PORTS(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`else
    sdram_port_arbiter #(.NUM_PORTS(N)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference grant rule: port 0 first, else scan 1..N-1 starting at rr pointer.
    function automatic int model_pick(input logic [N-1:0] p);
        int  rr_w;
        bit  frc;
        rr_w = -1;
        for (int k = 0; k < N - 1; k++) begin
            int q;
            q = 1 + ((m_rr - 1 + k) % (N - 1));
            if (p[q] && rr_w < 0) rr_w = q;
        end
        frc = 1'b0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        frc = (m_cnt == LIMIT) && (rr_w >= 0);
`endif
        if (p[0] && !frc) return 0;
        return rr_w;
    endfunction

    task automatic new_req(input int p, input logic [25:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] m);
        if (!bus.port_req[p]) begin
            bus.port_addr[p]  = a;
            bus.port_write[p] = w;
            bus.port_wdata[p] = d;
            bus.port_wmask[p] = m;
            bus.port_req[p]   = 1'b1;
        end
    endtask

    task automatic rand_req(input int p);
        new_req(p, 26'($urandom), 1'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic clear_ctrl();
        bus.sdram_ack      = 1'b0;
        bus.sdram_rdvalid  = 1'b0;
        bus.sdram_complete = 1'b0;
        bus.sdram_rdata    = '0;
    endtask

    // beats/same < 0 -> randomized; returns with DUT back in IDLE.
    task automatic do_txn(input int beats, input int same, input int dly, input bit do_rst);
        int          w;
        logic [25:0] ea;
        logic        ew;
        logic [31:0] ed;
        logic [3:0]  em;
        logic [31:0] rd;
        w = model_pick(bus.port_req);
        if (w < 0) begin
            chk("no_request", 0, 1);
            return;
        end
        ea = bus.port_addr[w];
        ew = bus.port_write[w];
        ed = bus.port_wdata[w];
        em = bus.port_wmask[w];
        if (same < 0)  same  = ew ? int'($urandom_range(0, 1)) : 0;
        if (beats < 0) beats = ew ? 0 : int'($urandom_range(1, 4));
        if (w == 0) m_cnt = (m_cnt == 31) ? 31 : m_cnt + 1;
        else        m_cnt = 0;
        last_w = w;
        tick();
        chk("sdram_req_set", bus.sdram_req, 1);
        chk("sdram_addr", bus.sdram_addr, ea);
        chk("sdram_write", bus.sdram_write, ew);
        chk("sdram_wdata", bus.sdram_wdata, ed);
        chk("sdram_wmask", bus.sdram_wmask, em);
        for (int i = 0; i < dly; i++) begin
            chk("ack_early", bus.port_ack, 0);
            tick();
            chk("sdram_req_hold", bus.sdram_req, 1);
        end
        bus.sdram_ack      = 1'b1;
        bus.sdram_complete = (same != 0);
        #1;
        chk("port_ack", bus.port_ack, 64'(1) << w);
        if (same != 0) chk("port_complete_same", bus.port_complete, 64'(1) << w);
        tick();
        clear_ctrl();
        bus.port_req[w] = 1'b0;
        #1;
        chk("sdram_req_clr", bus.sdram_req, 0);
        chk("port_ack_clr", bus.port_ack, 0);
        if (same == 0) begin
            if (do_rst) begin
                bus.sdram_rdvalid  = 1'b1;
                bus.sdram_complete = 1'b1;
                #2;
                reset = 1'b1;
                #1;
                chk("rst_sdram_req", bus.sdram_req, 0);
                chk("rst_port_rdvalid", bus.port_rdvalid, 0);
                chk("rst_port_complete", bus.port_complete, 0);
                chk("rst_port_ack", bus.port_ack, 0);
                @(posedge clk);
                #3;
                clear_ctrl();
                bus.port_req = '0;
                reset = 1'b0;
                m_rr  = 1;
                m_cnt = 0;
                return;
            end
            for (int b = 0; b < beats; b++) begin
                rd = $urandom;
                bus.sdram_rdvalid = 1'b1;
                bus.sdram_rdata   = rd;
                #1;
                chk("port_rdvalid", bus.port_rdvalid, 64'(1) << w);
                chk("port_rdata", bus.port_rdata, rd);
                tick();
                bus.sdram_rdvalid = 1'b0;
            end
            bus.sdram_complete = 1'b1;
            #1;
            chk("port_complete", bus.port_complete, 64'(1) << w);
            tick();
            clear_ctrl();
        end
        if (w != 0) m_rr = (w == N - 1) ? 1 : w + 1;
        #1;
        chk("idle_no_req", bus.sdram_req, 0);
    endtask

    task automatic idle_junk();
        bus.sdram_ack      = 1'b1;
        bus.sdram_rdvalid  = 1'b1;
        bus.sdram_complete = 1'b1;
        #1;
        chk("junk_ack", bus.port_ack, 0);
        chk("junk_rdvalid", bus.port_rdvalid, 0);
        chk("junk_complete", bus.port_complete, 0);
        tick();
        chk("junk_sdram_req", bus.sdram_req, 0);
        clear_ctrl();
    endtask

    initial begin
        int exp_a[7];
        int exp_g[10];
        int pr;
        exp_a = '{0, 1, 2, 0, 1, 0, 2};
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        n_total = 0;
        n_bad   = 0;
        m_rr    = 1;
        m_cnt   = 0;
        last_w  = -1;
        reset   = 1'b1;
        bus.port_req   = '0;
        bus.port_addr  = '0;
        bus.port_write = '0;
        bus.port_wdata = '0;
        bus.port_wmask = '0;
        clear_ctrl();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_sdram_req", bus.sdram_req, 0);
        chk("reset_sdram_addr", bus.sdram_addr, 0);
        chk("reset_sdram_write", bus.sdram_write, 0);
        chk("reset_sdram_wdata", bus.sdram_wdata, 0);
        chk("reset_sdram_wmask", bus.sdram_wmask, 0);
        chk("reset_port_ack", bus.port_ack, 0);
        chk("reset_port_complete", bus.port_complete, 0);
        reset = 1'b0;

        // Priority: all three, then again with port 0 re-requesting after a low-priority grant
        for (int p = 0; p < N; p++) rand_req(p);
        for (int t = 0; t < 3; t++) begin
            do_txn(-1, -1, t, 0);
            chk("order_prio", last_w, exp_a[t]);
        end
        for (int p = 0; p < N; p++) rand_req(p);
        for (int t = 3; t < 7; t++) begin
            do_txn(-1, -1, 0, 0);
            chk("order_prio_rereq", last_w, exp_a[t]);
            if (t == 4) rand_req(0);
        end

        // Round-robin wrap between ports 1 and 2
        for (int t = 0; t < 4; t++) begin
            rand_req(1);
            rand_req(2);
            do_txn(-1, -1, 0, 0);
            chk("order_rr", last_w, (t % 2) + 1);
        end
        bus.port_req = '0;
        idle_junk();

        new_req(1, 26'h000100, 1'b0, 32'h0, 4'h0);
        do_txn(4, 0, 1, 0);
        chk("single_read_owner", last_w, 1);

        new_req(2, 26'h0ABCDE, 1'b1, 32'hDEADBEEF, 4'h3);
        do_txn(0, 1, 0, 0);
        chk("same_cycle_owner", last_w, 2);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
        for (int t = 0; t < 10; t++) begin
            rand_req(0);
            rand_req(1);
            do_txn(-1, -1, 0, 0);
            chk("order_guard", last_w, exp_g[t]);
        end
        bus.port_req = '0;
        idle_junk();
`endif

        new_req(1, 26'h0000F0, 1'b0, 32'h0, 4'h0);
        do_txn(2, 0, 0, 1);
        new_req(2, 26'h0012F0, 1'b0, 32'h0, 4'h0);
        do_txn(2, 0, 0, 0);
        chk("post_reset_owner", last_w, 2);

        for (int t = 0; t < 150; t++) begin
            if (bus.port_req == '0 && $urandom_range(0, 4) == 0) idle_junk();
            for (int p = 0; p < N; p++)
                if ($urandom_range(0, 1) == 1) rand_req(p);
            if (bus.port_req == '0) begin
                pr = int'($urandom_range(0, N - 1));
                rand_req(pr);
            end
            do_txn(-1, -1, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 29) == 0) && (model_pick(bus.port_req) >= 0) &&
                   !bus.port_write[model_pick(bus.port_req)]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_sdram_port_arbiter
`default_nettype wire
